mod_tx_sequencer: RTL and testbench

- Control sequencer for the modulator transmit datapath (PRBS source plus polyphase FIR shaping filter).
- Generates three strobes: the sample-rate enable, the once-per-symbol valid/PRBS-advance, and the zero-fill control.
- Runs start/warm-up/run/flush sequencing so the filter output is marked valid only once its N_BAUDS-deep symbol history holds real data, and the tail is flushed on stop.
- Sits between the top-level switch/control logic and the prbs/fir_filter instances.

---
 rtl/mod_tx_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mod_tx_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mod_tx_sequencer.sv
// Transmit sequencer for the modulator datapath.
// Produces the sample-rate strobe, the once-per-symbol valid / PRBS advance and
// the zero-fill control. It walks IDLE -> WARMUP -> RUN -> FLUSH -> IDLE so that
// the shaping filter output is flagged valid only while its symbol history holds
// real data, and the filter tail is drained with zeros after a stop.
module mod_tx_sequencer #(
  parameter int OVER_SAMP = 8,
  parameter int NB_COUNT  = 3,
  parameter int N_BAUDS   = 7,
  parameter int NB_RATE   = 4
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [NB_RATE-1:0]  i_rate,
  output logic                o_enable,
  output logic                o_valid,
  output logic                o_prbs_en,
  output logic                o_zero_fill,
  output logic [NB_COUNT-1:0] o_phase,
  output logic                o_out_valid,
  output logic                o_busy
);

  localparam int NB_SYM = $clog2(N_BAUDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [NB_RATE-1:0]  div_q, div_d, rate_q, rate_d;
  logic [NB_COUNT-1:0] phase_q, phase_d;
  logic [NB_SYM-1:0]   sym_q, sym_d;
  logic                stop_pend_q, stop_pend_d;
  logic                enable_q, enable_d, valid_q, valid_d, prbs_en_q, prbs_en_d;
  logic                zero_fill_q, zero_fill_d, out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                tick, last_phase, last_sym;

  assign tick       = (state_q != S_IDLE) && (div_q == rate_q);
  assign last_phase = (phase_q == NB_COUNT'(OVER_SAMP - 1));
  assign last_sym   = (sym_q == NB_SYM'(N_BAUDS));

  // Next-state and registered-output logic; the sample divider and phase
  // counter run in every busy state, the case below layers the sequencing.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    rate_d      = rate_q;
    phase_d     = phase_q;
    sym_d       = sym_q;
    stop_pend_d = stop_pend_q;
    enable_d    = 1'b0;
    valid_d     = 1'b0;
    prbs_en_d   = 1'b0;
    zero_fill_d = zero_fill_q;
    out_valid_d = out_valid_q;

    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + NB_RATE'(1);
      if (tick) begin
        enable_d = 1'b1;
        phase_d  = phase_q + NB_COUNT'(1);
        if (phase_q == '0) begin
          valid_d   = 1'b1;
          prbs_en_d = (state_q != S_FLUSH);
          sym_d     = sym_q + NB_SYM'(1);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        div_d       = '0;
        zero_fill_d = 1'b0;
        out_valid_d = 1'b0;
        // a simultaneous stop cancels the start
        if (i_start && !i_stop) begin
          rate_d      = i_rate;
          phase_d     = '0;
          sym_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (i_stop) begin
          // abort without flushing: history never held valid data
          state_d     = S_IDLE;
          enable_d    = 1'b0;
          valid_d     = 1'b0;
          prbs_en_d   = 1'b0;
          div_d       = '0;
          phase_d     = '0;
          sym_d       = '0;
          out_valid_d = 1'b0;
        end else if (tick && last_phase && last_sym) begin
          state_d     = S_RUN;
          sym_d       = '0;
          out_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (i_stop) stop_pend_d = 1'b1;
        // leave only at a symbol boundary so no symbol is cut short
        if (tick && last_phase && stop_pend_q) begin
          state_d     = S_FLUSH;
          stop_pend_d = 1'b0;
          sym_d       = '0;
          zero_fill_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (tick && last_phase && last_sym) begin
          state_d     = S_IDLE;
          phase_d     = '0;
          div_d       = '0;
          zero_fill_d = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      rate_q      <= '0;
      phase_q     <= '0;
      sym_q       <= '0;
      stop_pend_q <= 1'b0;
      enable_q    <= 1'b0;
      valid_q     <= 1'b0;
      prbs_en_q   <= 1'b0;
      zero_fill_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      rate_q      <= rate_d;
      phase_q     <= phase_d;
      sym_q       <= sym_d;
      stop_pend_q <= stop_pend_d;
      enable_q    <= enable_d;
      valid_q     <= valid_d;
      prbs_en_q   <= prbs_en_d;
      zero_fill_q <= zero_fill_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign o_enable    = enable_q;
  assign o_valid     = valid_q;
  assign o_prbs_en   = prbs_en_q;
  assign o_zero_fill = zero_fill_q;
  assign o_phase     = phase_q;
  assign o_out_valid = out_valid_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_mod_tx_sequencer.sv
// Directed bench for mod_tx_sequencer: reset, rate-0 run with stop/flush,
// divider, warm-up abort, start/stop collision and async reset mid-flush.
module tb_mod_tx_sequencer;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic [3:0] i_rate = '0;
  logic       o_enable, o_valid, o_prbs_en, o_zero_fill, o_out_valid, o_busy;
  logic [2:0] o_phase;

  int total = 0;
  int bad   = 0;

  mod_tx_sequencer dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_rate(i_rate), .o_enable(o_enable), .o_valid(o_valid),
    .o_prbs_en(o_prbs_en), .o_zero_fill(o_zero_fill), .o_phase(o_phase),
    .o_out_valid(o_out_valid), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int k, input logic en, input logic vl,
                         input logic pe, input logic zf, input int ph, input logic ov,
                         input logic bs);
    string t;
    t = $sformatf("%s[%0d]", tag, k);
    chk({t, ".enable"},    32'(o_enable),    32'(en));
    chk({t, ".valid"},     32'(o_valid),     32'(vl));
    chk({t, ".prbs_en"},   32'(o_prbs_en),   32'(pe));
    chk({t, ".zero_fill"}, 32'(o_zero_fill), 32'(zf));
    chk({t, ".phase"},     32'(o_phase),     32'(ph));
    chk({t, ".out_valid"}, 32'(o_out_valid), 32'(ov));
    chk({t, ".busy"},      32'(o_busy),      32'(bs));
  endtask

  initial begin
    // ---- reset and idle
    step(); step();
    chk_all("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      chk_all("idle", k, 0, 0, 0, 0, 0, 0, 0);
    end

    // ---- rate 0 run, start ignored in RUN, double stop at phase 3, flush
    i_rate = 4'd0; i_start = 1'b1;
    step();                                   // E0 accepts start
    i_start = 1'b0;
    chk_all("run0", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 146; k++) begin
      i_start = (k == 70 || k == 100);
      i_stop  = (k == 84 || k == 85 || k == 100);
      step();
      chk_all("run", k,
              k <= 144,
              (k % 8 == 1) && k <= 144,
              (k % 8 == 1) && k <= 88,
              k >= 88 && k <= 143,
              (k <= 144) ? k % 8 : 0,
              k >= 56 && k <= 143,
              k <= 143);
    end
    i_start = 1'b0; i_stop = 1'b0;

    // ---- divider rate 3, i_rate change ignored, stop during warm-up aborts
    i_rate = 4'd3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk_all("div0", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 80; k++) begin
      if (k == 20) i_rate = 4'd0;
      step();
      chk_all("div", k,
              k % 4 == 0,
              (k % 4 == 0) && ((k / 4) % 8 == 1),
              (k % 4 == 0) && ((k / 4) % 8 == 1),
              0, (k / 4) % 8, 0, 1);
    end
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    chk_all("wabort", 81, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk_all("wabort_idle", k, 0, 0, 0, 0, 0, 0, 0);
    end

    // ---- start and stop together in IDLE
    i_start = 1'b1; i_stop = 1'b1;
    step();
    i_start = 1'b0; i_stop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_all("ststop", k, 0, 0, 0, 0, 0, 0, 0);
    end

    // ---- async reset in the middle of FLUSH
    i_rate = 4'd0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      i_stop = (k == 60);
      step();
    end
    chk("preflush.zero_fill", 32'(o_zero_fill), 32'd1);
    chk("preflush.busy",      32'(o_busy),      32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_all("arst", 0, 0, 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b1;
    step();
    chk_all("arst_idle", 1, 0, 0, 0, 0, 0, 0, 0);

    // fresh start after reset runs the full warm-up
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
      chk_all("rewarm", k, 1, k % 8 == 1, k % 8 == 1, 0, k % 8, k >= 56, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
